// File: rtl/memory_cycle_if.sv
// Data-memory req/ack bus between the memory stage and the data memory.
//   req   : transfer request, held until ack (or abort)
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   wdata : lane-steered write data
//   be    : byte enables
//   ack   : transfer complete; rdata is valid in the same cycle
//   rdata : read word
// master = memory stage side, slave = memory side.
interface memory_cycle_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output be,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  be,
    output ack,
    output rdata
  );
endinterface

// File: rtl/memory_cycle.sv
// RV32I memory stage. Runs loads/stores from the EX/MEM register over a req/ack
// data bus that may insert wait states, steers store lanes, extracts and extends
// load data, and drives the MEM/WB register.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-low reset
//   *M inputs      : EX/MEM pipeline fields; funct3 = InstrM[14:12]
//   dmem           : data-memory bus (master side)
//   stall_M        : hold IF/ID/EX and EX/MEM while an access waits
//   *W outputs     : MEM/WB register, ReadDataW is the extended load data
//   misalign_W     : one-cycle misaligned access fault
//   bus_err_W      : one-cycle bus timeout fault
module memory_cycle #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  LoadM,
  input  logic                  StoreM,
  input  logic [4:0]            RD_M,
  input  logic [31:0]           PCPlus4M,
  input  logic [31:0]           WriteDataM,
  input  logic [31:0]           ALU_ResultM,
  input  logic [31:0]           InstrM,
  memory_cycle_if.master        dmem,
  output logic                  stall_M,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [4:0]            RD_W,
  output logic [31:0]           PCPlus4W,
  output logic [31:0]           ALU_ResultW,
  output logic [31:0]           InstrW,
  output logic [31:0]           ReadDataW,
  output logic                  misalign_W,
  output logic                  bus_err_W
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        access;
  logic        misaligned;
  logic        done;
  logic        timeout_hit;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign funct3 = InstrM[14:12];
  assign lane   = ALU_ResultM[1:0];
  assign access = LoadM | StoreM;

  always_comb begin
    misaligned = 1'b0;
    if (access) begin
      unique case (funct3[1:0])
        2'b01:   misaligned = lane[0];
        2'b10:   misaligned = (lane != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Bus outputs, store steering and load extraction.
  always_comb begin
    dmem.addr  = {ALU_ResultM[31:2], 2'b00};
    dmem.we    = StoreM & ~LoadM;
    dmem.wdata = WriteDataM;
    dmem.be    = 4'hF;
    if (StoreM && !LoadM) begin
      unique case (funct3[1:0])
        2'b00: begin
          dmem.wdata = {4{WriteDataM[7:0]}};
          dmem.be    = 4'b0001 << lane;
        end
        2'b01: begin
          dmem.wdata = {2{WriteDataM[15:0]}};
          dmem.be    = lane[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem.wdata = WriteDataM;
          dmem.be    = 4'hF;
        end
      endcase
    end

    unique case (lane)
      2'b00:   rd_byte = dmem.rdata[7:0];
      2'b01:   rd_byte = dmem.rdata[15:8];
      2'b10:   rd_byte = dmem.rdata[23:16];
      default: rd_byte = dmem.rdata[31:24];
    endcase
    rd_half = lane[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    unique case (funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = dmem.rdata;
    endcase
  end

  // FSM next state and handshake. Gating with rst drops req/stall the instant
  // reset asserts, even while the state register still reads BUSY.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmem.req    = 1'b0;
    timeout_hit = 1'b0;
    stall_M     = 1'b0;

    unique case (state_q)
      StIdle: begin
        dmem.req = rst & access & ~misaligned;
        if (dmem.req && !dmem.ack) begin
          stall_M = 1'b1;
          state_d = StBusy;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StBusy: begin
        dmem.req = rst;
        if (dmem.ack) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == TimeoutCnt)) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
          cnt_d       = '0;
        end else begin
          stall_M = rst;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign done = dmem.req & dmem.ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: a bubble while stalled, otherwise one capture per access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= 5'd0;
      PCPlus4W    <= 32'h0;
      ALU_ResultW <= 32'h0;
      InstrW      <= NOP;
      ReadDataW   <= 32'h0;
      misalign_W  <= 1'b0;
      bus_err_W   <= 1'b0;
    end else if (stall_M) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= 5'd0;
      PCPlus4W    <= 32'h0;
      ALU_ResultW <= 32'h0;
      InstrW      <= NOP;
      ReadDataW   <= 32'h0;
      misalign_W  <= 1'b0;
      bus_err_W   <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~misaligned & ~timeout_hit;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      InstrW      <= InstrM;
      ReadDataW   <= (LoadM && done) ? load_data : 32'h0;
      misalign_W  <= misaligned;
      bus_err_W   <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        LoadM;
  logic        StoreM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;
  logic [31:0] InstrM;
  logic        stall_M;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] InstrW;
  logic [31:0] ReadDataW;
  logic        misalign_W;
  logic        bus_err_W;

  int n_cmp = 0;
  int n_bad = 0;

  memory_cycle_if dmem ();

  memory_cycle #(.TIMEOUT(4), .NOP(Nop)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .LoadM      (LoadM),
    .StoreM     (StoreM),
    .RD_M       (RD_M),
    .PCPlus4M   (PCPlus4M),
    .WriteDataM (WriteDataM),
    .ALU_ResultM(ALU_ResultM),
    .InstrM     (InstrM),
    .dmem       (dmem),
    .stall_M    (stall_M),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RD_W       (RD_W),
    .PCPlus4W   (PCPlus4W),
    .ALU_ResultW(ALU_ResultW),
    .InstrW     (InstrW),
    .ReadDataW  (ReadDataW),
    .misalign_W (misalign_W),
    .bus_err_W  (bus_err_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    RegWriteM   = 1'b0;
    ResultSrcM  = 2'b00;
    LoadM       = 1'b0;
    StoreM      = 1'b0;
    RD_M        = 5'd0;
    PCPlus4M    = 32'h0;
    WriteDataM  = 32'h0;
    ALU_ResultM = 32'h0;
    InstrM      = Nop;
    dmem.ack    = 1'b0;
    dmem.rdata  = 32'h0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    RegWriteM   = 1'b1;
    ResultSrcM  = 2'b01;
    LoadM       = 1'b1;
    StoreM      = 1'b0;
    RD_M        = rd;
    PCPlus4M    = addr + 32'h1000;
    WriteDataM  = 32'h0;
    ALU_ResultM = addr;
    InstrM      = {17'h0, f3, rd, 7'b0000011};
  endtask

  // Load with nwait wait states; expected extended value supplied by caller.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int nwait, input logic [31:0] exp);
    @(negedge clk);
    drive_load(f3, addr, 5'd9);
    for (int i = 0; i < nwait; i++) begin
      dmem.ack = 1'b0;
      #1 chk({tag, " stall"}, stall_M, 1'b1);
      @(posedge clk); #1;
      chk({tag, " bubble regwrite"}, RegWriteW, 1'b0);
      chk({tag, " bubble instr"}, InstrW, Nop);
      @(negedge clk);
    end
    dmem.ack   = 1'b1;
    dmem.rdata = rdata;
    #1 chk({tag, " release"}, stall_M, 1'b0);
    @(posedge clk); #1;
    chk({tag, " data"}, ReadDataW, exp);
    chk({tag, " regwrite"}, RegWriteW, 1'b1);
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();

    // Reset state
    #12;
    chk("rst instr", InstrW, Nop);
    chk("rst regwrite", RegWriteW, 1'b0);
    chk("rst readdata", ReadDataW, 32'h0);
    chk("rst req", dmem.req, 1'b0);
    chk("rst stall", stall_M, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 1: zero-wait lw
    @(negedge clk);
    drive_load(3'b010, 32'h100, 5'd5);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw0 req", dmem.req, 1'b1);
    chk("lw0 stall", stall_M, 1'b0);
    chk("lw0 addr", dmem.addr, 32'h100);
    chk("lw0 we", dmem.we, 1'b0);
    chk("lw0 be", dmem.be, 4'hF);
    @(posedge clk); #1;
    chk("lw0 data", ReadDataW, 32'hDEAD_BEEF);
    chk("lw0 regwrite", RegWriteW, 1'b1);
    chk("lw0 rd", RD_W, 5'd5);
    chk("lw0 pc4", PCPlus4W, 32'h1100);
    chk("lw0 instr", InstrW, 32'h0000_2283);
    @(negedge clk);
    drive_idle();
    #1 chk("idle req", dmem.req, 1'b0);

    // 2: lb / lbu with two wait states, byte lane 3
    run_load("lb2w", 3'b000, 32'h203, 32'h80FF_0011, 2, 32'hFFFF_FF80);
    run_load("lbu2w", 3'b100, 32'h203, 32'h80FF_0011, 2, 32'h0000_0080);
    // extra extraction patterns
    run_load("lh1w", 3'b001, 32'h212, 32'h8001_7FFF, 1, 32'hFFFF_8001);
    run_load("lhu0w", 3'b101, 32'h210, 32'h8001_9ABC, 0, 32'h0000_9ABC);

    // 3: sh to upper half
    @(negedge clk);
    RegWriteM   = 1'b0;
    StoreM      = 1'b1;
    ALU_ResultM = 32'h302;
    WriteDataM  = 32'h1234_ABCD;
    InstrM      = {17'h0, 3'b001, 5'd0, 7'b0100011};
    dmem.ack    = 1'b1;
    #1;
    chk("sh req", dmem.req, 1'b1);
    chk("sh we", dmem.we, 1'b1);
    chk("sh be", dmem.be, 4'b1100);
    chk("sh wdata", dmem.wdata, 32'hABCD_ABCD);
    chk("sh addr", dmem.addr, 32'h300);
    @(posedge clk); #1;
    chk("sh regwrite", RegWriteW, 1'b0);
    chk("sh readdata", ReadDataW, 32'h0);

    // sb lane 1
    @(negedge clk);
    ALU_ResultM = 32'h305;
    WriteDataM  = 32'h0000_005A;
    InstrM      = {17'h0, 3'b000, 5'd0, 7'b0100011};
    #1;
    chk("sb be", dmem.be, 4'b0010);
    chk("sb wdata", dmem.wdata, 32'h5A5A_5A5A);
    @(negedge clk);
    drive_idle();

    // 4: misaligned lw, a stray ack must be ignored
    @(negedge clk);
    drive_load(3'b010, 32'h401, 5'd7);
    dmem.ack = 1'b1;
    #1;
    chk("mis req", dmem.req, 1'b0);
    chk("mis stall", stall_M, 1'b0);
    @(posedge clk); #1;
    chk("mis flag", misalign_W, 1'b1);
    chk("mis regwrite", RegWriteW, 1'b0);
    chk("mis readdata", ReadDataW, 32'h0);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    chk("mis clear", misalign_W, 1'b0);

    // 5: timeout after four stall cycles
    @(negedge clk);
    drive_load(3'b010, 32'h500, 5'd3);
    for (int i = 0; i < 4; i++) begin
      #1 chk("to stall", stall_M, 1'b1);
      @(posedge clk); #1;
      chk("to bubble", RegWriteW, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("to release", stall_M, 1'b0);
    @(posedge clk); #1;
    chk("to buserr", bus_err_W, 1'b1);
    chk("to regwrite", RegWriteW, 1'b0);
    @(negedge clk);
    drive_idle();
    #1 chk("to idle req", dmem.req, 1'b0);
    @(posedge clk); #1;
    chk("to buserr clear", bus_err_W, 1'b0);

    // 6: reset in the third wait cycle
    @(negedge clk);
    drive_load(3'b010, 32'h600, 5'd4);
    @(posedge clk);
    @(posedge clk); #1;
    chk("rb stall", stall_M, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rb req", dmem.req, 1'b0);
    chk("rb stall drop", stall_M, 1'b0);
    chk("rb instr", InstrW, Nop);
    chk("rb regwrite", RegWriteW, 1'b0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    run_load("post rst lw", 3'b010, 32'h604, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
Memory stage of the RV32I pipeline. It consumes the EX/MEM pipeline outputs produced by the execute stage and runs each load or store over a req/ack data-memory bus that may insert wait states. It performs store lane steering and load extraction with sign or zero extension, and generates a pipeline stall plus alignment and timeout faults. It drives the MEM/WB register that feeds writeback.

Parameters:
TIMEOUT, 16, max BUSY cycles to wait for dmem_ack before aborting; 0 disables the timeout.
NOP, 32'h00000013, instruction word loaded into InstrW for bubbles.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
RegWriteM  in  1  register write enable from EX/MEM
ResultSrcM  in  2  writeback result select
LoadM  in  1  instruction is a load
StoreM  in  1  instruction is a store
RD_M  in  5  destination register
PCPlus4M  in  32  PC+4
WriteDataM  in  32  store data, already forwarded
ALU_ResultM  in  32  effective address / ALU result
InstrM  in  32  instruction word; funct3 = InstrM[14:12]
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address {ALU_ResultM[31:2],2'b00}
dmem_wdata  out  32  lane-steered store data
dmem_be  out  4  byte enables
dmem_ack  in  1  transfer complete; dmem_rdata valid this cycle
dmem_rdata  in  32  read word
stall_M  out  1  hold IF/ID/EX and EX/MEM stable
RegWriteW, ResultSrcW[1:0], RD_W[4:0], PCPlus4W[31:0], ALU_ResultW[31:0], InstrW[31:0]  out  MEM/WB register
ReadDataW  out  32  extended load data
misalign_W  out  1  misaligned access fault, one W cycle
bus_err_W  out  1  timeout fault, one W cycle

Behaviour:
- Reset is asynchronous and active-low. While rst=0:
  - State = IDLE and the timeout counter = 0.
  - All MEM/WB outputs = 0, except InstrW = NOP.
  - dmem_req = 0 and stall_M = 0 (both are combinational from IDLE).
- access = LoadM | StoreM.
- misaligned is true for:
  - funct3[1:0]=01 (h/hu) with addr[0]=1;
  - funct3[1:0]=10 (w) with addr[1:0]≠0.
- Store steering:
  - sb: wdata = {4{WriteDataM[7:0]}}, be = 4'b0001<<addr[1:0].
  - sh: wdata = {2{WriteDataM[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - sw: wdata = WriteDataM, be = 4'hF.
  - Loads drive be = 4'hF, we = 0.
- Load extraction:
  - Select the byte or half of dmem_rdata at addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- FSM IDLE / BUSY. Bus outputs are combinational from the current EX/MEM inputs.
- IDLE:
  - Aligned access: dmem_req = 1.
    - If dmem_ack the same cycle: zero-wait completion. MEM/WB captures normally and stall_M = 0.
    - Otherwise: stall_M = 1, next state BUSY, counter = 1.
  - Misaligned access: dmem_req = 0, stall_M = 0. MEM/WB captures with RegWriteW = 0 and misalign_W = 1.
  - No access: pass-through capture; ReadDataW = 0.
- BUSY:
  - dmem_req = 1 with identical we/addr/wdata/be. Upstream guarantees EX/MEM inputs are stable while stall_M = 1.
  - On dmem_ack: stall_M = 0, capture, next state IDLE.
  - Else if TIMEOUT≠0 and counter == TIMEOUT: abort. stall_M = 0, next state IDLE, capture with RegWriteW = 0 and bus_err_W = 1.
  - Otherwise: stall_M = 1, counter increments.
- While stall_M = 1, MEM/WB loads a bubble:
  - RegWriteW = 0, InstrW = NOP.
  - Faults = 0, other fields = 0.
  - A single completed access writes MEM/WB exactly once.
- dmem_ack while dmem_req = 0 is ignored.
- Latency: zero-wait access adds 0 stall cycles; n wait states give n stall cycles.
- misalign_W and bus_err_W are high for exactly one cycle per fault. The following capture clears them.
- Reset asserted in BUSY: dmem_req drops immediately (asynchronously) and the transfer is abandoned with no MEM/WB write.

Test Plan:
1. Zero-wait lw: addr 0x100, dmem_ack the same cycle, rdata 0xDEADBEEF -> stall_M never 1; next cycle ReadDataW = 0xDEADBEEF, RegWriteW = 1, RD_W matches.
2. lb with 2 wait states: addr 0x203, rdata 0x80FF0011 -> stall_M = 1 for 2 cycles; then ReadDataW = 0xFFFFFF80; lbu under the same conditions gives 0x00000080.
3. sh: addr 0x302, WriteDataM 0x1234ABCD -> dmem_we = 1, dmem_be = 4'b1100, dmem_wdata = 0xABCDABCD, dmem_addr = 0x300.
4. Misaligned lw: addr 0x401 -> dmem_req stays 0; misalign_W = 1 for one cycle; RegWriteW = 0.
5. Timeout: TIMEOUT = 4, lw, no ack -> stall_M = 1 for 4 cycles, then released; bus_err_W = 1 for one cycle; RegWriteW = 0; FSM returns to IDLE.
6. Reset mid-BUSY: rst = 0 in the third wait cycle -> dmem_req = 0 and stall_M = 0 immediately, InstrW = NOP; after release, a new lw completes normally.
